// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: next-PC select encoding, NOP word, default reset PC.
package fetch_unit_pkg;

  localparam int NPC_OP_LENGTH = 3;

  typedef enum logic [NPC_OP_LENGTH-1:0] {
    NPC_PC4    = 3'd0,
    NPC_BRANCH = 3'd1,
    NPC_JUMP   = 3'd2,
    NPC_JR     = 3'd3
  } npc_op_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  function automatic logic is_redirect_op(input logic [NPC_OP_LENGTH-1:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JR);
  endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Next-PC target mux: sequential, branch, jump and register-jump targets.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [NPC_OP_LENGTH-1:0] npc_op,
  input  logic [31:0]              pc,
  input  logic [31:0]              pc_d,
  input  logic [25:0]              instr_d,
  input  logic [31:0]              rs_data_d,
  output logic [31:0]              npc
);

  logic [31:0] pc_d_plus4;
  logic [31:0] br_offset;

  assign pc_d_plus4 = pc_d + 32'd4;
  assign br_offset  = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};

  always_comb begin
    npc = pc + 32'd4;
    case (npc_op)
      NPC_BRANCH: npc = pc_d_plus4 + br_offset;
      NPC_JUMP:   npc = {pc_d_plus4[31:28], instr_d, 2'b00};
      NPC_JR:     npc = rs_data_d & 32'hFFFF_FFFC;
      default:    npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC register, imem addressing, IF/ID register and redirect handling.
// FETCH_DELAY_SLOT_EN keeps the instruction fetched alongside a redirect (MIPS delay slot).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int          IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stallF,
  input  logic [NPC_OP_LENGTH-1:0]   npcOp,
  input  logic [31:0]                rsDataD,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic [31:0]                instrD,
  output logic [31:0]                pcD,
  output logic [31:0]                pc8D,
  output logic                       validD,
  output logic [5:0]                 opcodeD,
  output logic [5:0]                 funcD,
  output logic [4:0]                 rsD,
  output logic [4:0]                 rtD,
  output logic [4:0]                 rdD,
  output logic [15:0]                imm16D,
  output logic                       redirectF
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic        valid_q, valid_d;
  logic [31:0] npc;

  npc_calc u_npc_calc (
    .npc_op    (npcOp),
    .pc        (pc_q),
    .pc_d      (pcd_q),
    .instr_d   (instr_q[25:0]),
    .rs_data_d (rsDataD),
    .npc       (npc)
  );

  assign redirectF = valid_q & ~stallF & is_redirect_op(npcOp);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    valid_d = valid_q;
    if (!stallF) begin
      pcd_d = pc_q;
      if (redirectF) begin
        pc_d = npc;
`ifdef FETCH_DELAY_SLOT_EN
        instr_d = imem_rdata;
        valid_d = 1'b1;
`else
        // wrong-path fetch squashed into a bubble
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
`endif
      end else begin
        pc_d    = pc_q + 32'd4;
        instr_d = imem_rdata;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcd_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr = pc_q[IMEM_ADDR_WIDTH+1:2];
  assign instrD    = instr_q;
  assign pcD       = pcd_q;
  assign pc8D      = pcd_q + 32'd8;
  assign validD    = valid_q;
  assign opcodeD   = instr_q[31:26];
  assign funcD     = instr_q[5:0];
  assign rsD       = instr_q[25:21];
  assign rtD       = instr_q[20:16];
  assign rdD       = instr_q[15:11];
  assign imm16D    = instr_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, random vs model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic [2:0]  npcOp;
  logic [31:0] rsDataD;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instrD, pcD, pc8D;
  logic        validD;
  logic [5:0]  opcodeD, funcD;
  logic [4:0]  rsD, rtD, rdD;
  logic [15:0] imm16D;
  logic        redirectF;

  logic [31:0] imem [0:1023];
  assign imem_rdata = imem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stallF(stallF), .npcOp(npcOp), .rsDataD(rsDataD),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .instrD(instrD), .pcD(pcD),
    .pc8D(pc8D), .validD(validD), .opcodeD(opcodeD), .funcD(funcD), .rsD(rsD),
    .rtD(rtD), .rdD(rdD), .imm16D(imm16D), .redirectF(redirectF)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic [2:0]  op;
    logic [31:0] rs;
    logic        exp_redir;
    logic [31:0] exp_pc;
    logic [31:0] exp_pcd;
    logic [31:0] exp_instr;
    logic        exp_valid;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic [2:0] o,
                              input logic [31:0] rs, input logic rd, input logic [31:0] pc,
                              input logic [31:0] pcd, input logic [31:0] ins, input logic v);
    vec_t t;
    t.rst = r; t.stall = s; t.op = o; t.rs = rs; t.exp_redir = rd;
    t.exp_pc = pc; t.exp_pcd = pcd; t.exp_instr = ins; t.exp_valid = v;
    return t;
  endfunction

  function automatic logic [31:0] bub(input logic [31:0] slot_word);
    return DS ? slot_word : 32'h0;
  endfunction

  task automatic check_regs(input string tag, input logic [31:0] pc, input logic [31:0] pcd,
                            input logic [31:0] ins, input logic v);
    chk({tag, "_pcD"}, pcD, pcd);
    chk({tag, "_instrD"}, instrD, ins);
    chk({tag, "_validD"}, {31'd0, validD}, {31'd0, v});
    chk({tag, "_imem_addr"}, {22'd0, imem_addr}, {22'd0, pc[11:2]});
    chk({tag, "_pc8D"}, pc8D, pcd + 32'd8);
    chk({tag, "_fields"}, {opcodeD, funcD, rsD, rtD}, {ins[31:26], ins[5:0], ins[25:21], ins[20:16]});
    chk({tag, "_rd_imm"}, {11'd0, rdD, imm16D}, {11'd0, ins[15:11], ins[15:0]});
  endtask

  vec_t vecs [25];

  // reference model state
  logic [31:0] m_pc, m_pcd, m_instr;
  logic        m_valid;

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = i + 1;
    imem[4] = 32'h1000_FFFC;   // beq, imm -4
    imem[8] = 32'h0C00_0C10;   // jal 0x3040

    vecs[0]  = mk(0, 0, NPC_PC4,    0, 0, 32'h3004, 32'h3000, 32'h1, 1);
    vecs[1]  = mk(0, 0, NPC_PC4,    0, 0, 32'h3008, 32'h3004, 32'h2, 1);
    vecs[2]  = mk(0, 0, NPC_PC4,    0, 0, 32'h300C, 32'h3008, 32'h3, 1);
    vecs[3]  = mk(0, 1, NPC_PC4,    0, 0, 32'h300C, 32'h3008, 32'h3, 1);
    vecs[4]  = mk(0, 1, NPC_PC4,    0, 0, 32'h300C, 32'h3008, 32'h3, 1);
    vecs[5]  = mk(0, 1, NPC_PC4,    0, 0, 32'h300C, 32'h3008, 32'h3, 1);
    vecs[6]  = mk(0, 0, NPC_PC4,    0, 0, 32'h3010, 32'h300C, 32'h4, 1);
    vecs[7]  = mk(0, 0, NPC_PC4,    0, 0, 32'h3014, 32'h3010, 32'h1000_FFFC, 1);
    vecs[8]  = mk(0, 0, NPC_BRANCH, 0, 1, 32'h3004, 32'h3014, bub(32'h6), DS);
    vecs[9]  = mk(0, 0, DS ? NPC_PC4 : NPC_BRANCH, 0, 0, 32'h3008, 32'h3004, 32'h2, 1);
    vecs[10] = mk(0, 0, NPC_PC4,    0, 0, 32'h300C, 32'h3008, 32'h3, 1);
    vecs[11] = mk(0, 1, NPC_BRANCH, 0, 0, 32'h300C, 32'h3008, 32'h3, 1);
    vecs[12] = mk(0, 0, NPC_BRANCH, 0, 1, 32'h3018, 32'h300C, bub(32'h4), DS);
    vecs[13] = mk(0, 0, NPC_PC4,    0, 0, 32'h301C, 32'h3018, 32'h7, 1);
    vecs[14] = mk(0, 0, NPC_PC4,    0, 0, 32'h3020, 32'h301C, 32'h8, 1);
    vecs[15] = mk(0, 0, NPC_PC4,    0, 0, 32'h3024, 32'h3020, 32'h0C00_0C10, 1);
    vecs[16] = mk(0, 0, NPC_JUMP,   0, 1, 32'h3040, 32'h3024, bub(32'hA), DS);
    vecs[17] = mk(0, 0, NPC_PC4,    0, 0, 32'h3044, 32'h3040, 32'h11, 1);
    vecs[18] = mk(0, 0, NPC_JR, 32'h3047, 1, 32'h3044, 32'h3044, bub(32'h12), DS);
    vecs[19] = mk(0, 0, NPC_PC4,    0, 0, 32'h3048, 32'h3044, 32'h12, 1);
    vecs[20] = mk(0, 0, NPC_JR, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h3048, bub(32'h13), DS);
    vecs[21] = mk(0, 0, NPC_PC4,    0, 0, 32'h0, 32'hFFFF_FFFC, 32'h400, 1);
    vecs[22] = mk(0, 0, NPC_PC4,    0, 0, 32'h4, 32'h0, 32'h1, 1);
    vecs[23] = mk(0, 0, 3'd5,       0, 0, 32'h8, 32'h4, 32'h2, 1);
    vecs[24] = mk(1, 0, NPC_BRANCH, 0, 1, 32'h3000, 32'h0, 32'h0, 0);

    // reset
    rst = 1'b1; stallF = 1'b0; npcOp = NPC_PC4; rsDataD = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    check_regs("reset", 32'h3000, 32'h0, 32'h0, 1'b0);
    chk("reset_redirectF", {31'd0, redirectF}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; stallF = vecs[i].stall; npcOp = vecs[i].op; rsDataD = vecs[i].rs;
      #1;
      chk($sformatf("vec%0d_redirectF", i), {31'd0, redirectF}, {31'd0, vecs[i].exp_redir});
      @(posedge clk); #1;
      check_regs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pcd,
                 vecs[i].exp_instr, vecs[i].exp_valid);
    end

    // reset takes priority over a stall
    rst = 1'b0; stallF = 1'b0; npcOp = NPC_PC4;
    @(posedge clk); #1;
    check_regs("pre_rst_stall", 32'h3004, 32'h3000, 32'h1, 1'b1);
    rst = 1'b1; stallF = 1'b1;
    @(posedge clk); #1;
    check_regs("rst_stall", 32'h3000, 32'h0, 32'h0, 1'b0);

    // randomized run against the behavioural model
    m_pc = 32'h3000; m_pcd = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic        e_redir;
      logic [31:0] tgt, m_fetch;
      rst     = ($urandom_range(0, 49) == 0);
      stallF  = ($urandom_range(0, 3) == 0);
      npcOp   = 3'($urandom_range(0, 7));
      rsDataD = ($urandom_range(0, 1) == 0) ? $urandom : (32'h3000 + 32'($urandom_range(0, 4095)));
      e_redir = m_valid && !stallF && (npcOp >= 3'd1) && (npcOp <= 3'd3);
      case (npcOp)
        3'd1:    tgt = m_pcd + 32'd4 + 32'($signed(m_instr[15:0])) * 32'd4;
        3'd2:    tgt = ((m_pcd + 32'd4) & 32'hF000_0000) | ({6'd0, m_instr[25:0]} * 32'd4);
        3'd3:    tgt = rsDataD - (rsDataD % 32'd4);
        default: tgt = m_pc + 32'd4;
      endcase
      m_fetch = imem[m_pc[11:2]];
      #1;
      chk("rnd_redirectF", {31'd0, redirectF}, {31'd0, e_redir});
      if (rst) begin
        m_pc = 32'h3000; m_pcd = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      end else if (!stallF) begin
        m_pcd = m_pc;
        if (e_redir) begin
          m_instr = DS ? m_fetch : 32'h0;
          m_valid = DS;
          m_pc    = tgt;
        end else begin
          m_instr = m_fetch;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
      end
      @(posedge clk); #1;
      chk("rnd_pcD", pcD, m_pcd);
      chk("rnd_instrD", instrD, m_instr);
      chk("rnd_validD", {31'd0, validD}, {31'd0, m_valid});
      chk("rnd_imem_addr", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
